// File: rtl/tape_dev_if.sv
// Host stream and I/O unit handshake bundle for the tape device.
// The device side uses the slave modport.
interface tape_dev_if;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] rx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [4:0] tx_data;
    logic       input_rdy_to_io;
    logic       input_ack_from_io;
    logic [4:0] input_data_to_io;
    logic       output_rdy_from_io;
    logic       output_ack_to_io;
    logic [4:0] output_data_from_io;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        output input_ack_from_io,
        output output_rdy_from_io,
        output output_data_from_io,
        input  rx_ready,
        input  tx_valid,
        input  tx_data,
        input  input_rdy_to_io,
        input  input_data_to_io,
        input  output_ack_to_io
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        input  input_ack_from_io,
        input  output_rdy_from_io,
        input  output_data_from_io,
        output rx_ready,
        output tx_valid,
        output tx_data,
        output input_rdy_to_io,
        output input_data_to_io,
        output output_ack_to_io
    );
endinterface

// File: rtl/tape_dev.sv
// Tape device model: FIFO-buffered reader and punch halves between the
// host stream and the I/O unit's 4-phase handshakes.
module tape_dev #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    tape_dev_if.slave   bus,
    input  logic        reader_enable_from_pnl,
    input  logic        flush_from_pnl,
    output logic [15:0] read_count,
    output logic [15:0] punch_count
);

    typedef enum logic [1:0] {
        R_IDLE,
        R_RDY,
        R_WAIT
    } r_state_t;

    typedef enum logic {
        P_IDLE,
        P_ACK
    } p_state_t;

    logic [4:0]  r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        r_full;
    logic        r_empty;
    logic        r_push;
    logic        r_pop;
    logic        r_done;
    r_state_t    r_state;
    r_state_t    r_next;
    logic [4:0]  hold;

    logic [4:0]  p_mem [DEPTH];
    logic [AW:0] p_wp;
    logic [AW:0] p_rp;
    logic        p_full;
    logic        p_empty;
    logic        p_push;
    logic        p_pop;
    p_state_t    p_state;
    p_state_t    p_next;
    logic [15:0] punch_cnt;

    assign r_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign r_empty = (r_wp == r_rp);

    assign p_full  = (p_wp[AW] != p_rp[AW]) &&
                     (p_wp[AW-1:0] == p_rp[AW-1:0]);
    assign p_empty = (p_wp == p_rp);

    // Flush wins over any push or pop in the same cycle.
    assign r_push = bus.rx_valid && !r_full && !flush_from_pnl;
    assign r_pop  = (r_state == R_IDLE) && !r_empty &&
                    reader_enable_from_pnl &&
                    !bus.input_ack_from_io && !flush_from_pnl;

    assign p_push = (p_state == P_IDLE) && bus.output_rdy_from_io &&
                    !p_full && !flush_from_pnl;
    assign p_pop  = !p_empty && bus.tx_ready && !flush_from_pnl;

    assign bus.rx_ready         = !r_full;
    assign bus.tx_valid         = !p_empty;
    assign bus.tx_data          = p_mem[p_rp[AW-1:0]];
    assign bus.input_data_to_io = hold;
    assign punch_count          = punch_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (flush_from_pnl) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (r_push) r_wp <= r_wp + 1'b1;
            if (r_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_push) r_mem[r_wp[AW-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (r_pop) r_next = R_RDY;
            R_RDY:   if (bus.input_ack_from_io) r_next = R_WAIT;
            R_WAIT:  if (!bus.input_ack_from_io) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        bus.input_rdy_to_io = (r_state == R_RDY);
        r_done = (r_state == R_WAIT) && !bus.input_ack_from_io;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold       <= '0;
            read_count <= '0;
        end else begin
            if (r_pop)  hold <= r_mem[r_rp[AW-1:0]];
            if (r_done) read_count <= read_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            p_wp <= '0;
            p_rp <= '0;
        end else if (flush_from_pnl) begin
            p_wp <= '0;
            p_rp <= '0;
        end else begin
            if (p_push) p_wp <= p_wp + 1'b1;
            if (p_pop)  p_rp <= p_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (p_push) p_mem[p_wp[AW-1:0]] <= bus.output_data_from_io;
    end

    always_ff @(posedge clk) begin
        if (!resetn) p_state <= P_IDLE;
        else         p_state <= p_next;
    end

    // A full FIFO keeps the punch in P_IDLE, withholding ack.
    always_comb begin
        p_next = p_state;
        unique case (p_state)
            P_IDLE:  if (p_push) p_next = P_ACK;
            P_ACK:   if (!bus.output_rdy_from_io) p_next = P_IDLE;
            default: p_next = P_IDLE;
        endcase
    end

    always_comb begin
        bus.output_ack_to_io = (p_state == P_ACK);
    end

    always_ff @(posedge clk) begin
        if (!resetn)     punch_cnt <= '0;
        else if (p_push) punch_cnt <= punch_cnt + 16'd1;
    end

endmodule

// File: tb/tb_tape_dev.sv
// Directed bench for tape_dev: reader order and latency, backpressure,
// flush mid-handshake and counter wrap.
module tb_tape_dev;
    logic        clk = 1'b0;
    logic        resetn;
    logic        reader_enable_from_pnl;
    logic        flush_from_pnl;
    logic [15:0] read_count;
    logic [15:0] punch_count;
    int          total = 0;
    int          bad = 0;

    tape_dev_if bus();

    tape_dev #(.DEPTH(16), .AW(4)) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .bus                    (bus),
        .reader_enable_from_pnl (reader_enable_from_pnl),
        .flush_from_pnl         (flush_from_pnl),
        .read_count             (read_count),
        .punch_count            (punch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic read_one(input logic [4:0] exp, input string tag);
        int n = 0;
        while (bus.input_rdy_to_io !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.input_rdy_to_io !== 1'b1) begin
            chk({tag, "_to"}, 16'(bus.input_rdy_to_io), 16'd1);
        end else begin
            chk(tag, 16'(bus.input_data_to_io), 16'(exp));
            bus.input_ack_from_io = 1'b1;
            @(negedge clk);
            chk({tag, "_fall"}, 16'(bus.input_rdy_to_io), 16'd0);
            bus.input_ack_from_io = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic punch_one(input logic [4:0] d, input string tag);
        int n = 0;
        bus.output_rdy_from_io  = 1'b1;
        bus.output_data_from_io = d;
        @(negedge clk);
        while (bus.output_ack_to_io !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack"}, 16'(bus.output_ack_to_io), 16'd1);
        bus.output_rdy_from_io = 1'b0;
        @(negedge clk);
        chk({tag, "_ackfall"}, 16'(bus.output_ack_to_io), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] exp;
        resetn                  = 1'b0;
        reader_enable_from_pnl  = 1'b0;
        flush_from_pnl          = 1'b0;
        bus.rx_valid            = 1'b0;
        bus.rx_data             = '0;
        bus.tx_ready            = 1'b0;
        bus.input_ack_from_io   = 1'b0;
        bus.output_rdy_from_io  = 1'b0;
        bus.output_data_from_io = '0;
        repeat (2) @(negedge clk);

        chk("rst_rx_ready", 16'(bus.rx_ready), 16'd1);
        chk("rst_tx_valid", 16'(bus.tx_valid), 16'd0);
        chk("rst_in_rdy", 16'(bus.input_rdy_to_io), 16'd0);
        chk("rst_out_ack", 16'(bus.output_ack_to_io), 16'd0);
        chk("rst_in_data", 16'(bus.input_data_to_io), 16'd0);
        chk("rst_rcnt", read_count, 16'd0);
        chk("rst_pcnt", punch_count, 16'd0);
        resetn = 1'b1;

        // Read order and first-rdy latency
        reader_enable_from_pnl = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 5'h13;
        @(negedge clk);
        chk("rdy_early", 16'(bus.input_rdy_to_io), 16'd0);
        bus.rx_data = 5'h06;
        @(negedge clk);
        chk("rdy_lat", 16'(bus.input_rdy_to_io), 16'd1);
        chk("data_lat", 16'(bus.input_data_to_io), 16'h13);
        bus.rx_data = 5'h07;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        read_one(5'h13, "rd0");
        read_one(5'h06, "rd1");
        read_one(5'h07, "rd2");
        chk("rcnt3", read_count, 16'd3);

        // Reader full with the panel disabled
        reader_enable_from_pnl = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("rx_rdy_15", 16'(bus.rx_ready), 16'd1);
            bus.rx_valid = 1'b1;
            bus.rx_data  = 5'(i * 2 + 1);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        chk("rx_full", 16'(bus.rx_ready), 16'd0);
        chk("no_rd_dis", 16'(bus.input_rdy_to_io), 16'd0);
        reader_enable_from_pnl = 1'b1;
        @(negedge clk);
        chk("rx_back", 16'(bus.rx_ready), 16'd1);
        chk("rdy_back", 16'(bus.input_rdy_to_io), 16'd1);
        for (int i = 0; i < 16; i++) read_one(5'(i * 2 + 1), "rdf");
        chk("rcnt19", read_count, 16'd19);

        // Punch backpressure
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) punch_one(5'(16 + i), "pn");
        chk("tx_valid_full", 16'(bus.tx_valid), 16'd1);
        bus.output_rdy_from_io  = 1'b1;
        bus.output_data_from_io = 5'h06;
        repeat (3) begin
            @(negedge clk);
            chk("ack_held", 16'(bus.output_ack_to_io), 16'd0);
        end
        chk("tx_head", 16'(bus.tx_data), 16'h10);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        chk("ack_still", 16'(bus.output_ack_to_io), 16'd0);
        @(negedge clk);
        chk("ack17", 16'(bus.output_ack_to_io), 16'd1);
        bus.output_rdy_from_io = 1'b0;
        @(negedge clk);
        chk("ack17_fall", 16'(bus.output_ack_to_io), 16'd0);
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 5'(17 + i) : 5'h06;
            chk("tx_v", 16'(bus.tx_valid), 16'd1);
            chk("tx_d", 16'(bus.tx_data), 16'(exp));
            bus.tx_ready = 1'b1;
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
        chk("tx_empty", 16'(bus.tx_valid), 16'd0);
        chk("pcnt17", punch_count, 16'd17);

        // Flush while the reader presents 0x11
        reader_enable_from_pnl = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 5'(8'h11 + i);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        reader_enable_from_pnl = 1'b1;
        @(negedge clk);
        chk("fl_rdy", 16'(bus.input_rdy_to_io), 16'd1);
        chk("fl_data", 16'(bus.input_data_to_io), 16'h11);
        flush_from_pnl = 1'b1;
        @(negedge clk);
        flush_from_pnl = 1'b0;
        chk("fl_rx_ready", 16'(bus.rx_ready), 16'd1);
        chk("fl_rdy_hold", 16'(bus.input_rdy_to_io), 16'd1);
        read_one(5'h11, "fl_rd");
        chk("fl_rcnt", read_count, 16'd20);
        repeat (6) begin
            @(negedge clk);
            chk("fl_no_rdy", 16'(bus.input_rdy_to_io), 16'd0);
        end

        // Punch counter wrap, then flush the punch side
        force dut.punch_cnt = 16'hffff;
        @(negedge clk);
        release dut.punch_cnt;
        chk("pc_forced", punch_count, 16'hffff);
        punch_one(5'h0a, "pw");
        chk("pc_wrap", punch_count, 16'h0000);
        chk("pw_data", 16'(bus.tx_data), 16'h0a);
        flush_from_pnl = 1'b1;
        @(negedge clk);
        flush_from_pnl = 1'b0;
        chk("pfl_empty", 16'(bus.tx_valid), 16'd0);
        chk("pfl_rcnt", read_count, 16'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
